// File: rtl/soc_loader_pkg.sv
// Shared types and widths for the imem loader and its byte packer.
package soc_loader_pkg;

   localparam int LANE_W    = 8;
   localparam int WORD_W    = 32;
   localparam int LANES     = WORD_W / LANE_W;
   localparam int REL_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      RELEASE
   } loader_state_e;

endpackage

// File: rtl/soc_byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words; lane 0 is bits 7:0.
module soc_byte_packer
   import soc_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_accept,
   input  logic [LANE_W-1:0] i_data,
   input  logic              i_take_partial,
   output logic              o_word_valid,
   output logic [WORD_W-1:0] o_word,
   output logic [WORD_W-1:0] o_partial,
   output logic              o_has_partial
);

   logic [LANES-1:0][LANE_W-1:0] r_lanes;
   logic [1:0]                   r_byte_idx;
   logic                         r_word_valid;
   logic [WORD_W-1:0]            r_word;

   // Lanes are zeroed after every completed word so a flushed partial word has zero fill.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_lanes      <= '0;
         r_byte_idx   <= '0;
         r_word_valid <= 1'b0;
         r_word       <= '0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_accept) begin
            if (r_byte_idx == 2'(LANES - 1)) begin
               r_word       <= {i_data, r_lanes[LANES-2:0]};
               r_word_valid <= 1'b1;
               r_lanes      <= '0;
            end else begin
               r_lanes[r_byte_idx] <= i_data;
            end
            r_byte_idx <= r_byte_idx + 2'd1;
         end else if (i_take_partial) begin
            r_lanes    <= '0;
            r_byte_idx <= '0;
         end
      end
   end

   assign o_word_valid  = r_word_valid;
   assign o_word        = r_word;
   assign o_partial     = r_lanes;
   assign o_has_partial = (r_byte_idx != 2'd0);

endmodule

// File: rtl/soc_imem_loader.sv
// Loads a byte stream into imem from word 0 while holding the CPU in reset;
// otherwise passes the CPU fetch port straight through to imem.
module soc_imem_loader
   import soc_loader_pkg::*;
#(
   parameter int IMEM_AW        = 10,
   parameter int RELEASE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_imem,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic               rx_ready,
   input  logic [IMEM_AW-1:0] cpu_imem_addr,
   input  logic               cpu_imem_rd,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               imem_rd,
   output logic               imem_wr,
   output logic [31:0]        imem_wdata,
   output logic               cpu_hold_reset,
   output logic               load_busy,
   output logic               load_done,
   output logic [IMEM_AW:0]   word_count,
   output logic               overflow
);

   loader_state_e        r_state;
   loader_state_e        w_next;
   logic                 r_load_q;
   logic                 r_overflow;
   logic                 r_load_done;
   logic [IMEM_AW-1:0]   r_wr_addr;
   logic [IMEM_AW:0]     r_word_count;
   logic [REL_CNT_W-1:0] r_rel_cnt;

   logic w_rise, w_fall, w_accept, w_start, w_wr, w_take_partial, w_done_set, w_rx_ready;
   logic w_word_valid, w_has_partial;
   logic [WORD_W-1:0] w_word, w_partial;

   assign w_rise   = load_imem & ~r_load_q;
   assign w_fall   = ~load_imem & r_load_q;
   assign w_accept = rx_valid & w_rx_ready;

   soc_byte_packer u_packer (
      .clk            (clk),
      .reset          (reset),
      .i_clear        (w_start),
      .i_accept       (w_accept),
      .i_data         (rx_data),
      .i_take_partial (w_take_partial),
      .o_word_valid   (w_word_valid),
      .o_word         (w_word),
      .o_partial      (w_partial),
      .o_has_partial  (w_has_partial)
   );

   // A pending full word always drains before the partial word in FLUSH.
   always_comb begin
      w_next         = r_state;
      w_rx_ready     = 1'b0;
      cpu_hold_reset = 1'b0;
      imem_addr      = cpu_imem_addr;
      imem_rd        = cpu_imem_rd;
      imem_wdata     = '0;
      w_wr           = 1'b0;
      w_start        = 1'b0;
      w_take_partial = 1'b0;
      w_done_set     = 1'b0;
      if (r_state != IDLE) begin
         cpu_hold_reset = 1'b1;
         imem_rd        = 1'b0;
         imem_addr      = r_wr_addr;
      end
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_next  = LOAD;
               w_start = 1'b1;
            end
         end
         LOAD: begin
            w_rx_ready = 1'b1;
            if (w_word_valid) begin
               w_wr       = 1'b1;
               imem_wdata = w_word;
            end
            if (w_fall) w_next = FLUSH;
         end
         FLUSH: begin
            if (w_word_valid) begin
               w_wr       = 1'b1;
               imem_wdata = w_word;
               if (!w_has_partial) w_next = RELEASE;
            end else if (w_has_partial) begin
               w_wr           = 1'b1;
               imem_wdata     = w_partial;
               w_take_partial = 1'b1;
               w_next         = RELEASE;
            end else begin
               w_next = RELEASE;
            end
         end
         RELEASE: begin
            if (w_rise) begin
               w_next  = LOAD;
               w_start = 1'b1;
            end else if (r_rel_cnt <= REL_CNT_W'(1)) begin
               w_next     = IDLE;
               w_done_set = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_load_q     <= 1'b0;
         r_wr_addr    <= '0;
         r_word_count <= '0;
         r_overflow   <= 1'b0;
         r_load_done  <= 1'b0;
         r_rel_cnt    <= '0;
      end else begin
         r_state     <= w_next;
         r_load_q    <= load_imem;
         r_load_done <= w_done_set;
         if (w_start) begin
            r_wr_addr    <= '0;
            r_word_count <= '0;
            r_overflow   <= 1'b0;
         end else if (w_wr) begin
            r_wr_addr <= r_wr_addr + 1'b1;
            if (r_wr_addr == '1) r_overflow <= 1'b1;
            if (r_word_count != '1) r_word_count <= r_word_count + 1'b1;
         end
         // Counter reaches zero on the same edge the FSM returns to IDLE.
         if (r_state == FLUSH && w_next == RELEASE)
            r_rel_cnt <= REL_CNT_W'(RELEASE_CYCLES);
         else if (r_state == RELEASE && r_rel_cnt != '0)
            r_rel_cnt <= r_rel_cnt - 1'b1;
      end
   end

   assign rx_ready   = w_rx_ready;
   assign imem_wr    = w_wr;
   assign load_busy  = (r_state != IDLE);
   assign load_done  = r_load_done;
   assign word_count = r_word_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_soc_imem_loader.sv
// Scoreboard bench: two loaders (1024-word and 4-word imem) share one stimulus stream.
module tb_soc_imem_loader;

   localparam int REL = 4;

   logic       clk = 1'b0;
   logic       reset, load_imem, rx_valid, cpu_imem_rd;
   logic [7:0] rx_data;
   logic [9:0] cpu_imem_addr;

   logic        a_rx_ready, a_imem_rd, a_imem_wr, a_hold, a_busy, a_done, a_ovf;
   logic [9:0]  a_imem_addr;
   logic [31:0] a_imem_wdata;
   logic [10:0] a_wc;
   logic        b_rx_ready, b_imem_rd, b_imem_wr, b_hold, b_busy, b_done, b_ovf;
   logic [1:0]  b_imem_addr;
   logic [31:0] b_imem_wdata;
   logic [2:0]  b_wc;

   int vectors = 0;
   int misc = 0;
   int cyc = 0;
   int aLastWr = 0;
   int bLastWr = 0;
   int aDoneCnt = 0;
   int bDoneCnt = 0;
   int expDone = 0;

   logic [31:0] expAddrA[$], expDataA[$], expAddrB[$], expDataB[$];
   logic [7:0]  bq[$];

   int          mIdx;
   logic [31:0] mLanes;
   int          mWords;

   soc_imem_loader #(.IMEM_AW(10), .RELEASE_CYCLES(REL)) dutA (
      .clk(clk), .reset(reset), .load_imem(load_imem), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(a_rx_ready), .cpu_imem_addr(cpu_imem_addr), .cpu_imem_rd(cpu_imem_rd),
      .imem_addr(a_imem_addr), .imem_rd(a_imem_rd), .imem_wr(a_imem_wr), .imem_wdata(a_imem_wdata),
      .cpu_hold_reset(a_hold), .load_busy(a_busy), .load_done(a_done), .word_count(a_wc),
      .overflow(a_ovf)
   );

   soc_imem_loader #(.IMEM_AW(2), .RELEASE_CYCLES(REL)) dutB (
      .clk(clk), .reset(reset), .load_imem(load_imem), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(b_rx_ready), .cpu_imem_addr(cpu_imem_addr[1:0]), .cpu_imem_rd(cpu_imem_rd),
      .imem_addr(b_imem_addr), .imem_rd(b_imem_rd), .imem_wr(b_imem_wr), .imem_wdata(b_imem_wdata),
      .cpu_hold_reset(b_hold), .load_busy(b_busy), .load_done(b_done), .word_count(b_wc),
      .overflow(b_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         misc++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic failNow(input string nm);
      vectors++;
      misc++;
      $display("[TB] FAIL %s", nm);
   endtask

   // Reference model: a load is just a byte list cut into little-endian words at word index n.
   task automatic modelStart();
      mIdx = 0;
      mLanes = '0;
      mWords = 0;
   endtask

   task automatic pushWord(input logic [31:0] w);
      expAddrA.push_back(32'(mWords % 1024));
      expDataA.push_back(w);
      expAddrB.push_back(32'(mWords % 4));
      expDataB.push_back(w);
      mWords++;
   endtask

   task automatic modelAccept(input logic [7:0] b);
      mLanes[8*mIdx +: 8] = b;
      mIdx++;
      if (mIdx == 4) begin
         pushWord(mLanes);
         mLanes = '0;
         mIdx = 0;
      end
   endtask

   task automatic modelFlush();
      if (mIdx != 0) pushWord(mLanes);
      mIdx = 0;
      mLanes = '0;
   endtask

   always @(negedge clk) begin : monA
      logic [31:0] ea, ed;
      if (a_imem_wr) begin
         aLastWr = cyc;
         if (expAddrA.size() == 0) failNow("a_unexpected_write");
         else begin
            ea = expAddrA.pop_front();
            ed = expDataA.pop_front();
            checkOutput("a_wr_addr", 32'(a_imem_addr), ea);
            checkOutput("a_wr_data", a_imem_wdata, ed);
         end
      end
      if (a_done) aDoneCnt++;
   end

   always @(negedge clk) begin : monB
      logic [31:0] ea, ed;
      if (b_imem_wr) begin
         bLastWr = cyc;
         if (expAddrB.size() == 0) failNow("b_unexpected_write");
         else begin
            ea = expAddrB.pop_front();
            ed = expDataB.pop_front();
            checkOutput("b_wr_addr", 32'(b_imem_addr), ea);
            checkOutput("b_wr_data", b_imem_wdata, ed);
         end
      end
      if (b_done) bDoneCnt++;
   end

   task automatic applyStimulus(input logic [7:0] b, input int gap, input bit drop);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = b;
      cpu_imem_addr = 10'($urandom);
      cpu_imem_rd = 1'($urandom);
      if (drop) load_imem = 1'b0;
      #1;
      checkOutput("a_rx_ready_load", 32'(a_rx_ready), 32'd1);
      checkOutput("b_rx_ready_load", 32'(b_rx_ready), 32'd1);
      checkOutput("a_hold_load", 32'(a_hold), 32'd1);
      checkOutput("a_rd_load", 32'(a_imem_rd), 32'd0);
      modelAccept(b);
      if (drop) modelFlush();
   endtask

   task automatic startLoad();
      @(negedge clk);
      cpu_imem_addr = 10'($urandom);
      cpu_imem_rd = 1'($urandom);
      #1;
      checkOutput("a_idle_addr", 32'(a_imem_addr), 32'(cpu_imem_addr));
      checkOutput("a_idle_rd", 32'(a_imem_rd), 32'(cpu_imem_rd));
      checkOutput("b_idle_addr", 32'(b_imem_addr), 32'(cpu_imem_addr[1:0]));
      checkOutput("b_idle_rd", 32'(b_imem_rd), 32'(cpu_imem_rd));
      checkOutput("a_idle_wr", 32'(a_imem_wr), 32'd0);
      checkOutput("a_idle_hold", 32'(a_hold), 32'd0);
      checkOutput("a_idle_ready", 32'(a_rx_ready), 32'd0);
      load_imem = 1'b1;
      modelStart();
   endtask

   task automatic finishLoad();
      bit found = 1'b0;
      int n;
      @(negedge clk);
      rx_valid = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (a_done) found = 1'b1;
      end
      n = mWords;
      if (!found) failNow("done_timeout");
      else begin
         checkOutput("done_latency", 32'(cyc - aLastWr), 32'(REL + 1));
         checkOutput("b_load_done", 32'(b_done), 32'd1);
         checkOutput("a_word_count", 32'(a_wc), 32'(n));
         checkOutput("a_overflow", 32'(a_ovf), 32'(n >= 1024));
         checkOutput("b_word_count", 32'(b_wc), 32'((n > 7) ? 7 : n));
         checkOutput("b_overflow", 32'(b_ovf), 32'(n >= 4));
         checkOutput("a_hold_after", 32'(a_hold), 32'd0);
         checkOutput("a_busy_after", 32'(a_busy), 32'd0);
      end
      expDone++;
   endtask

   task automatic sendAll(input int gapMax);
      for (int i = 0; i < bq.size(); i++)
         applyStimulus(bq[i], (gapMax == 0) ? 0 : int'($urandom_range(gapMax, 1)), i == bq.size() - 1);
   endtask

   task automatic doLoad(input int gapMax);
      startLoad();
      sendAll(gapMax);
      finishLoad();
   endtask

   task automatic fillRandom(input int n);
      bq.delete();
      repeat (n) bq.push_back(8'($urandom));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset = 1'b1;
      load_imem = 1'b0;
      rx_valid = 1'b0;
      rx_data = '0;
      cpu_imem_addr = 10'h3F;
      cpu_imem_rd = 1'b1;
      modelStart();
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", 32'(a_busy), 32'd0);
      checkOutput("rst_hold", 32'(a_hold), 32'd0);
      checkOutput("rst_word_count", 32'(a_wc), 32'd0);
      checkOutput("rst_overflow", 32'(a_ovf), 32'd0);
      checkOutput("rst_done", 32'(a_done), 32'd0);
      checkOutput("rst_ready", 32'(a_rx_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("idle_addr_3f", 32'(a_imem_addr), 32'h3F);
      checkOutput("idle_rd_pass", 32'(a_imem_rd), 32'd1);
      checkOutput("idle_wr_zero", 32'(a_imem_wr), 32'd0);

      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      doLoad(0);
      bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
      doLoad(0);
      fillRandom(20);
      doLoad(0);
      fillRandom(24);
      doLoad(7);
      doLoad(0);
      fillRandom(40);
      doLoad(3);

      // Restart from RELEASE: a new rising edge aborts the release, no load_done.
      fillRandom(7);
      startLoad();
      sendAll(0);
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("release_hold", 32'(a_hold), 32'd1);
      checkOutput("release_busy", 32'(b_busy), 32'd1);
      checkOutput("release_ready", 32'(a_rx_ready), 32'd0);
      load_imem = 1'b1;
      modelStart();
      fillRandom(5);
      sendAll(2);
      finishLoad();

      // Reset mid-load with load_imem still high: partial discarded, then a fresh load.
      fillRandom(6);
      startLoad();
      for (int i = 0; i < 6; i++) applyStimulus(bq[i], 0, 1'b0);
      @(negedge clk);
      rx_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("midrst_busy", 32'(a_busy), 32'd0);
      checkOutput("midrst_hold", 32'(a_hold), 32'd0);
      checkOutput("midrst_word_count", 32'(a_wc), 32'd0);
      checkOutput("midrst_wr", 32'(a_imem_wr), 32'd0);
      checkOutput("midrst_b_busy", 32'(b_busy), 32'd0);
      checkOutput("midrst_b_hold", 32'(b_hold), 32'd0);
      mIdx = 0;
      mLanes = '0;
      reset = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("rise_at_reset_exit", 32'(a_busy), 32'd1);
      modelStart();
      fillRandom(3);
      sendAll(0);
      finishLoad();

      for (int r = 0; r < 4; r++) begin
         fillRandom(int'($urandom_range(16, 1)));
         doLoad(int'($urandom_range(3, 0)));
      end

      repeat (5) @(negedge clk);
      checkOutput("a_pending_writes", 32'(expAddrA.size()), 32'd0);
      checkOutput("b_pending_writes", 32'(expAddrB.size()), 32'd0);
      checkOutput("a_done_count", 32'(aDoneCnt), 32'(expDone));
      checkOutput("b_done_count", 32'(bDoneCnt), 32'(expDone));
      checkOutput("b_last_write_sync", 32'(bLastWr), 32'(aLastWr));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
      $finish;
   end

endmodule
